// File: rtl/aes192_key_expander.sv
// AES-192 key schedule: one expansion step (six words) per clock into a
// 52-word register file, with a registered round-key read port.
module aes192_key_expander #(
  parameter int NR = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [191:0] key,
  input  logic [3:0]   rd_idx,
  output logic         busy,
  output logic         done,
  output logic         key_valid,
  output logic [127:0] round_key
);

  typedef enum logic {IDLE, EXPAND} state_t;

  localparam logic [3:0] NR_L = 4'(NR);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]),
            sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  state_t        state_q, state_d;
  logic [3:0]    step_q, step_d;
  logic          done_q, done_d;
  logic          kv_q, kv_d;
  logic [127:0]  rk_q, rk_d;
  logic [31:0]   w_q [52];
  logic [31:0]   w_d [52];

  logic          acc;
  logic [5:0]    base;
  logic [5:0]    wi;
  logic [5:0]    rb;
  logic [3:0]    rsel;
  logic [7:0]    rcon;
  logic [31:0]   prev;
  logic [31:0]   t;
  logic [31:0]   nw;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    kv_d    = kv_q;
    done_d  = 1'b0;
    w_d     = w_q;
    acc     = 1'b0;
    base    = '0;
    wi      = '0;
    rcon    = '0;
    t       = '0;
    nw      = '0;
    prev    = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc     = 1'b1;
          w_d[0]  = key[191:160];
          w_d[1]  = key[159:128];
          w_d[2]  = key[127:96];
          w_d[3]  = key[95:64];
          w_d[4]  = key[63:32];
          w_d[5]  = key[31:0];
          step_d  = 4'd1;
          kv_d    = 1'b0;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        base = {2'b00, step_q} * 6'd6;
        rcon = 8'd1 << (step_q - 4'd1);
        t    = sub_word({w_q[base - 6'd1][23:0],
                         w_q[base - 6'd1][31:24]})
               ^ {rcon, 24'h0};
        prev = t;
        // Step 8 stops at w51; its last two words are never stored.
        for (int j = 0; j < 6; j++) begin
          wi   = base + 6'(j);
          nw   = w_q[wi - 6'd6] ^ prev;
          prev = nw;
          if (wi <= 6'd51) w_d[wi] = nw;
        end
        if (step_q == 4'd8) begin
          state_d = IDLE;
          step_d  = 4'd0;
          kv_d    = 1'b1;
          done_d  = 1'b1;
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rsel = (rd_idx <= NR_L) ? rd_idx : 4'd0;
    rb   = {rsel, 2'b00};
    rk_d = '0;
    if (kv_q && (rd_idx <= NR_L) && !acc)
      rk_d = {w_q[rb], w_q[rb + 6'd1],
              w_q[rb + 6'd2], w_q[rb + 6'd3]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      done_q  <= 1'b0;
      kv_q    <= 1'b0;
      rk_q    <= '0;
      for (int i = 0; i < 52; i++) w_q[i] <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      done_q  <= done_d;
      kv_q    <= kv_d;
      rk_q    <= rk_d;
      w_q     <= w_d;
    end
  end

  assign busy      = (state_q == EXPAND);
  assign done      = done_q;
  assign key_valid = kv_q;
  assign round_key = rk_q;

endmodule

// File: tb/tb_aes192_key_expander.sv
// Directed bench for aes192_key_expander with an arithmetic
// (GF(2^8) inverse + affine) reference key schedule.
module tb_aes192_key_expander;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [191:0] key_i;
  logic [3:0]   rd_idx;
  logic         busy;
  logic         done;
  logic         key_valid;
  logic [127:0] round_key;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mw [52];

  localparam logic [191:0] KEY_A2 =
    192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [191:0] KEY_B =
    192'h000102030405060708090a0b0c0d0e0f1011121314151617;

  aes192_key_expander #(.NR(12)) dut (
    .clk(clk), .reset(reset), .start(start), .key(key_i),
    .rd_idx(rd_idx), .busy(busy), .done(done),
    .key_valid(key_valid), .round_key(round_key)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int i = 1; i < 256; i++)
      if (gmul(x, 8'(i)) == 8'h01) inv = 8'(i);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
               ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  task automatic expand_model(input logic [191:0] k);
    logic [31:0] tw;
    logic [7:0]  rc;
    for (int i = 0; i < 6; i++) mw[i] = k[191 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 6; i < 52; i++) begin
      tw = mw[i-1];
      if (i % 6 == 0) begin
        tw = {tw[23:0], tw[31:24]};
        tw = {ref_sbox(tw[31:24]), ref_sbox(tw[23:16]),
              ref_sbox(tw[15:8]), ref_sbox(tw[7:0])};
        tw = tw ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      mw[i] = mw[i-6] ^ tw;
    end
  endtask

  function automatic logic [127:0] model_rk(input int k);
    return {mw[4*k], mw[4*k+1], mw[4*k+2], mw[4*k+3]};
  endfunction

  // Issues start, then watches busy/done for n samples after the start edge;
  // optionally raises start again with key ikey at sample inj.
  task automatic run_expansion(input logic [191:0] k, input int n,
                               input int inj, input logic [191:0] ikey,
                               output int bcnt, output int dcnt,
                               output int dat);
    bcnt = 0; dcnt = 0; dat = -1;
    key_i = k;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (busy) bcnt++;
      if (done) begin dcnt++; dat = c; end
      if (c == inj) begin key_i = ikey; start = 1'b1; end
      else start = 1'b0;
      tick();
    end
    start = 1'b0;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      logic [127:0] exp_rk;
      rd_idx = 4'(i);
      tick();
      exp_rk = (i <= 12) ? model_rk(i) : 128'h0;
      n_checks++;
      if (round_key !== exp_rk)
        $display("FAIL %s idx%0d: got %h want %h",
                 tag, i, round_key, exp_rk);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; key_i = '0; rd_idx = 4'd0;
    #3;
    n_checks++;
    if ({busy, done, key_valid, round_key} !== 131'h0)
      $display("FAIL reset_outs: got b%b d%b v%b rk %h want all 0",
               busy, done, key_valid, round_key);
    else n_pass++;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_read_before_expand();
    int bad = 0;
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      tick();
      if (round_key !== 128'h0 || key_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0)
      $display("FAIL idle_read: got %0d nonzero reads want 0", bad);
    else n_pass++;
  endtask

  task automatic test_a2();
    int bc, dc, da;
    logic [127:0] exp_a2 [3];
    int idxs [3];
    exp_a2[0] = 128'h8e73b0f7da0e6452c810f32b809079e5;
    exp_a2[1] = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
    exp_a2[2] = 128'he98ba06f448c773c8ecc720401002202;
    idxs[0] = 0; idxs[1] = 1; idxs[2] = 12;
    rd_idx = 4'd0;
    run_expansion(KEY_A2, 12, -1, '0, bc, dc, da);
    n_checks++;
    if (bc != 8) $display("FAIL a2_busy: got %0d want 8", bc);
    else n_pass++;
    n_checks++;
    if (dc != 1 || da != 8)
      $display("FAIL a2_done: got cnt %0d at %0d want 1 at 8", dc, da);
    else n_pass++;
    n_checks++;
    if (key_valid !== 1'b1)
      $display("FAIL a2_valid: got %b want 1", key_valid);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      rd_idx = 4'(idxs[i]);
      tick();
      n_checks++;
      if (round_key !== exp_a2[i])
        $display("FAIL a2_rk%0d: got %h want %h",
                 idxs[i], round_key, exp_a2[i]);
      else n_pass++;
    end
  endtask

  task automatic test_sweep();
    expand_model(KEY_A2);
    sweep("sweep");
  endtask

  task automatic test_start_while_busy();
    int bc, dc, da;
    run_expansion(KEY_A2, 14, 3, {192{1'b1}}, bc, dc, da);
    n_checks++;
    if (bc != 8) $display("FAIL busy_start_busy: got %0d want 8", bc);
    else n_pass++;
    n_checks++;
    if (dc != 1 || da != 8)
      $display("FAIL busy_start_done: got cnt %0d at %0d want 1 at 8",
               dc, da);
    else n_pass++;
    expand_model(KEY_A2);
    sweep("busy_start");
  endtask

  task automatic test_restart();
    int bad = 0;
    int seen = 0;
    rd_idx = 4'd12;
    key_i = KEY_B;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (key_valid !== 1'b0)
      $display("FAIL restart_valid_drop: got %b want 0", key_valid);
    else n_pass++;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      if (done) seen = 1;
      else if (round_key !== 128'h0) bad++;
      if (seen == 0) tick();
    end
    n_checks++;
    if (seen == 0) $display("FAIL restart_done: got none want pulse");
    else n_pass++;
    n_checks++;
    if (bad != 0)
      $display("FAIL restart_zero: got %0d nonzero reads want 0", bad);
    else n_pass++;
    expand_model(KEY_B);
    tick();
    n_checks++;
    if (round_key !== model_rk(12))
      $display("FAIL restart_rk12: got %h want %h",
               round_key, model_rk(12));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int bc, dc, da;
    int bad = 0;
    rd_idx = 4'd0;
    key_i = KEY_A2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, key_valid, round_key} !== 131'h0)
      $display("FAIL midreset_outs: got b%b d%b v%b rk %h want all 0",
               busy, done, key_valid, round_key);
    else n_pass++;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      tick();
      if (round_key !== 128'h0 || key_valid !== 1'b0 || busy !== 1'b0)
        bad++;
    end
    n_checks++;
    if (bad != 0)
      $display("FAIL midreset_reads: got %0d bad reads want 0", bad);
    else n_pass++;
    run_expansion(KEY_A2, 12, -1, '0, bc, dc, da);
    n_checks++;
    if (dc != 1 || da != 8)
      $display("FAIL midreset_done: got cnt %0d at %0d want 1 at 8",
               dc, da);
    else n_pass++;
    expand_model(KEY_A2);
    sweep("midreset");
  endtask

  initial begin
    test_reset();
    test_read_before_expand();
    test_a2();
    test_sweep();
    test_start_while_busy();
    test_restart();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/aes192_key_expander.md
# aes192_key_expander

Iterative AES-192 key-schedule engine that sits directly upstream of the AES-192 encrypt/decrypt round datapaths. It replaces the eight-stage combinational key-expansion chain with one expansion step per clock. All 52 schedule words are stored in a register file, and any of the 13 round keys (0..12) can be served on demand through a registered read port. Encrypt consumes keys 0→12, and decrypt consumes keys 12→0 through the same port.

## Interface
Parameters:
- NR, 12, number of rounds; round-key indices are 0..NR. Fixed for AES-192; other values are unsupported.

Ports:
- clk  in  1  rising-edge clock, the single clock for the block
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to expand `key`; ignored while busy=1
- key  in  192  cipher key; w0 = key[191:160] … w5 = key[31:0]; sampled only on an accepted start
- rd_idx  in  4  round-key index to read
- busy  out  1  expansion in progress
- done  out  1  one-cycle pulse when expansion completes
- key_valid  out  1  schedule complete and stable
- round_key  out  128  registered round key for the previous cycle's rd_idx

## Operation
- Storage: w[0..51], each 32 bits. Round key k = {w[4k], w[4k+1], w[4k+2], w[4k+3]}, with w[4k] at bits [127:96].
- The FSM has two states, IDLE and EXPAND, plus a step counter `step` (4 bits, 1..8).
- In IDLE, start=1 does the following on that edge:
  - loads w[0..5] from key;
  - sets step=1, busy=1, key_valid=0;
  - enters EXPAND.
- In EXPAND, each edge performs one step i = step:
  - t = SubWord(RotWord(w[6i-1])) ^ {Rcon[i], 24'h0}, using the existing 4-byte SubBytes block;
  - w[6i] = w[6i-6] ^ t;
  - w[6i+j] = w[6i+j-6] ^ w[6i+j-1] for j = 1..5;
  - step 8 writes only w[48..51]; words 52/53 are neither computed nor stored;
  - Rcon[1..8] = 01, 02, 04, 08, 10, 20, 40, 80 (hex).
- On the step-8 edge: state→IDLE, busy=0, key_valid=1, done=1 for exactly one cycle.
- Read path: each edge, round_key ← (key_valid && rd_idx ≤ NR) ? round key[rd_idx] : 128'h0.
- start while busy is ignored. The in-flight expansion continues unchanged, and no restart is queued.
- start while IDLE with key_valid=1 restarts expansion. key_valid drops on that same edge, and round_key reads 0 until the new schedule completes.
- rd_idx of 13..15 returns 0 regardless of key_valid.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - state=IDLE, step=0;
  - busy=0, done=0, key_valid=0;
  - round_key=0;
  - w[*]=0.
- Reset mid-expansion aborts immediately. key_valid stays 0 until a fresh start completes.
- Latency is measured with start sampled at edge T:
  - busy=1 after T;
  - w[6..11] written at T+1;
  - w[48..51] written, done=1 and key_valid=1 after T+8;
  - busy is high for 8 cycles;
  - done falls after T+9.
- Earliest valid read: rd_idx applied during the cycle after T+8 gives round_key valid after edge T+9.
- Read latency is 1 cycle; back-to-back index changes give one key per cycle.
- Critical path is one SubBytes plus 6 chained 32-bit XORs.

## Test plan
- FIPS-197 A.2 key:
  - stimulus: start with key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, then read idx 0, 1, 12;
  - required: 8e73b0f7da0e6452c810f32b809079e5, 62f8ead2522c6b7bfe0c91f72402f5a5, e98ba06f448c773c8ecc720401002202;
  - required: done pulses exactly once, 8 cycles after start.
- Sweep: read idx 0..12 on consecutive cycles and compare each against the software model; idx 13, 14, 15 → 0.
- start while busy:
  - stimulus: second start with key all-FF at step 4;
  - required: schedule still matches the A.2 key, busy stays high for exactly 8 cycles, and there is a single done pulse.
- Restart after valid:
  - stimulus: new start with key 000102…1617;
  - required: key_valid drops on the start edge, round_key=0 during expansion, then idx 12 equals the model value for the new key.
- Reset at step 5:
  - required: busy/done/key_valid/round_key go to 0 immediately (asynchronous), and all reads return 0;
  - stimulus: a subsequent start;
  - required: correct A.2 schedule.
- Read before any expansion: after reset, any rd_idx → round_key = 0 and key_valid = 0.
